// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM states, opcode fields, cond codes.
// Optional call stack is enabled by PROGRAM_SEQUENCER_CALL_STACK_EN.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_FETCH_TGT = 3'd2,
    ST_EXEC      = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // Instruction word [7:6] selects the sequencer class, [5:4] the op.
  localparam logic [1:0] SEQ_CLASS = 2'b11;
  localparam logic [1:0] OP_JMP    = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_RET    = 2'b10;
  localparam logic [1:0] OP_HALT   = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_S0     = 2'b01;
  localparam logic [1:0] COND_S1     = 2'b10;
  localparam logic [1:0] COND_S2     = 2'b11;

  localparam int STACK_DEPTH = 4;

endpackage

// File: rtl/program_sequencer_jump_cond.sv
// Combinational jump condition: selects a status flag (or always) from the cond field.
module jump_cond
  import program_sequencer_pkg::*;
(
  input  logic [1:0] opcode,
  input  logic [2:0] status,
  output logic       jump
);

  always_comb begin
    jump = 1'b0;
    case (opcode)
      COND_ALWAYS: jump = 1'b1;
      COND_S0:     jump = status[0];
      COND_S1:     jump = status[1];
      COND_S2:     jump = status[2];
      default:     jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch/decode sequencer with JMP/CALL/RET/HALT and a datapath exec handshake.
// Define PROGRAM_SEQUENCER_CALL_STACK_EN to add a 4-entry return stack and o_stack_err.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic                  o_imem_req,
  input  logic                  i_imem_ack,
  input  logic [7:0]            i_imem_data,
  input  logic [2:0]            i_status,
  input  logic                  i_status_we,
  output logic [7:0]            o_instr,
  output logic                  o_exec,
  input  logic                  i_exec_done,
  output logic                  o_halted,
  output state_t                o_state
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  ,
  output logic                  o_stack_err
`endif
);

  // Handshake: a fetch word transfers on the rising edge where o_imem_req and
  // i_imem_ack are both 1; o_imem_req/o_imem_addr stay stable until then.
  // o_exec stays 1 until the rising edge that samples i_exec_done=1.

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [7:0]            word;
  logic [2:0]            status_q;
  logic                  jump;

  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign tgt         = ADDR_WIDTH'(i_imem_data);
  assign o_imem_addr = pc;
  assign o_state     = state;

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [2:0]            sp;
  logic [1:0]            sp_top;
  assign sp_top = sp[1:0] - 2'd1;
`endif

  jump_cond u_jump_cond (
    .opcode (word[1:0]),
    .status (status_q),
    .jump   (jump)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_FETCH;
      pc         <= ADDR_WIDTH'(RESET_PC);
      word       <= 8'h00;
      status_q   <= 3'b000;
      o_instr    <= 8'h00;
      o_exec     <= 1'b0;
      o_imem_req <= 1'b0;
      o_halted   <= 1'b0;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
      sp          <= 3'd0;
      o_stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
`endif
    end else begin
      if (i_status_we) status_q <= i_status;
      case (state)
        ST_FETCH: begin
          // Request rises one cycle after entry from reset; acks while low are dropped.
          if (!o_imem_req) begin
            o_imem_req <= 1'b1;
          end else if (i_imem_ack) begin
            word       <= i_imem_data;
            pc         <= pc_inc;
            o_imem_req <= 1'b0;
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (word[7:6] != SEQ_CLASS) begin
            o_instr <= word;
            o_exec  <= 1'b1;
            state   <= ST_EXEC;
          end else begin
            case (word[5:4])
              OP_JMP, OP_CALL: begin
                o_imem_req <= 1'b1;
                state      <= ST_FETCH_TGT;
              end
              OP_RET: begin
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
                if (sp == 3'd0) begin
                  o_stack_err <= 1'b1;
                end else begin
                  pc <= stack_mem[sp_top];
                  sp <= sp - 3'd1;
                end
`endif
                o_imem_req <= 1'b1;
                state      <= ST_FETCH;
              end
              default: begin
                o_halted <= 1'b1;
                state    <= ST_HALT;
              end
            endcase
          end
        end
        ST_FETCH_TGT: begin
          // Request stays high: the next fetch starts right at the updated PC.
          if (o_imem_req && i_imem_ack) begin
            state <= ST_FETCH;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
            if (word[5:4] == OP_CALL && jump) begin
              if (sp == 3'(STACK_DEPTH)) begin
                o_stack_err <= 1'b1;
                pc          <= pc_inc;
              end else begin
                stack_mem[sp[1:0]] <= pc_inc;
                sp                 <= sp + 3'd1;
                pc                 <= tgt;
              end
            end else
`endif
            pc <= jump ? tgt : pc_inc;
          end
        end
        ST_EXEC: begin
          if (i_exec_done) begin
            o_exec     <= 1'b0;
            o_imem_req <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_HALT: begin
          o_imem_req <= 1'b0;
        end
        default: begin
          o_imem_req <= 1'b0;
          state      <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: instruction-level reference interpreter plus expected fetch-address queue.
// Works with and without PROGRAM_SEQUENCER_CALL_STACK_EN.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int ADDR_W = 8;
  localparam int RST_PC = 0;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              o_imem_req;
  logic              i_imem_ack = 1'b0;
  logic [7:0]        i_imem_data = 8'h00;
  logic [2:0]        i_status = 3'b000;
  logic              i_status_we = 1'b0;
  logic [7:0]        o_instr;
  logic              o_exec;
  logic              i_exec_done = 1'b0;
  logic              o_halted;
  state_t            state_dbg;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  logic              o_stack_err;
`endif

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_WIDTH(ADDR_W), .RESET_PC(RST_PC)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .o_imem_addr (o_imem_addr),
    .o_imem_req  (o_imem_req),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .i_status    (i_status),
    .i_status_we (i_status_we),
    .o_instr     (o_instr),
    .o_exec      (o_exec),
    .i_exec_done (i_exec_done),
    .o_halted    (o_halted),
    .o_state     (state_dbg)
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    ,
    .o_stack_err (o_stack_err)
`endif
  );

  // ---------------- reference model state ----------------
  logic [7:0]        mem [256];
  logic [ADDR_W-1:0] m_pc;
  logic [2:0]        m_status;
  logic [ADDR_W-1:0] m_stack[$];
  logic              m_err;
  logic [ADDR_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    i_rst = 1'b1; i_imem_ack = 1'b0; i_exec_done = 1'b0; i_status_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", o_imem_req, 0);
    check("rst_exec", o_exec, 0);
    check("rst_halted", o_halted, 0);
    check("rst_instr", o_instr, 8'h00);
    check("rst_addr", o_imem_addr, RST_PC);
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    check("rst_stack_err", o_stack_err, 0);
`endif
    i_rst = 1'b0;
    m_pc = ADDR_W'(RST_PC); m_status = 3'b000; m_stack.delete(); m_err = 1'b0; exp_q.delete();
    @(negedge clk);
    check("first_req", o_imem_req, 1);
  endtask

  task automatic set_status(input logic [2:0] s);
    i_status = s; i_status_we = 1'b1;
    @(negedge clk);
    i_status_we = 1'b0;
    m_status = s;
  endtask

  // Serve one fetch; dly<0 picks a random 0..2 cycle ack delay.
  task automatic fetch_word(input int dly, output logic [7:0] w);
    int n;
    logic [ADDR_W-1:0] a, e;
    n = 0;
    w = 8'h00;
    while (!o_imem_req && n < 40) begin
      i_imem_ack  = ($urandom_range(0, 3) == 0);
      i_imem_data = 8'hF0;
      i_exec_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    i_imem_ack = 1'b0; i_exec_done = 1'b0;
    if (!o_imem_req) begin
      check("fetch_timeout", 0, 1);
      return;
    end
    if (dly < 0) dly = $urandom_range(0, 2);
    a = o_imem_addr;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check("req_hold", {o_imem_req, o_imem_addr}, {1'b1, a});
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : ~o_imem_addr;
    check("fetch_addr", o_imem_addr, e);
    w = mem[o_imem_addr];
    i_imem_ack = 1'b1; i_imem_data = w;
    @(negedge clk);
    i_imem_ack = 1'b0; i_imem_data = 8'($urandom);
  endtask

  task automatic run_exec(input logic [7:0] w);
    int d;
    check("exec_lat", o_exec, 0);
    @(negedge clk);
    check("exec_on", o_exec, 1);
    check("instr", o_instr, w);
    check("halted_lo", o_halted, 0);
    d = $urandom_range(0, 3);
    for (int k = 0; k < d; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        i_status = 3'($urandom); i_status_we = 1'b1; m_status = i_status;
      end
      @(negedge clk);
      i_status_we = 1'b0;
      check("exec_hold", o_exec, 1);
    end
    i_exec_done = 1'b1;
    @(negedge clk);
    i_exec_done = 1'b0;
    check("exec_clr", o_exec, 0);
  endtask

  // Execute one instruction on the model while serving the DUT.
  task automatic step(input int dly);
    logic [7:0] w, t;
    bit taken;
    exp_q.push_back(m_pc);
    fetch_word(dly, w);
    m_pc = m_pc + 1'b1;
    if (w[7:6] != 2'b11) begin
      run_exec(w);
    end else if (w[5:4] == 2'b11) begin
      for (int k = 0; k < 20; k++) begin
        i_imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("halt_flag", o_halted, 1);
        check("halt_req", o_imem_req, 0);
      end
      i_imem_ack = 1'b0;
    end else if (w[5:4] == 2'b10) begin
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
`endif
      @(negedge clk);
    end else begin
      exp_q.push_back(m_pc);
      fetch_word(-1, t);
      taken = (w[1:0] == 2'b00) ? 1'b1 : m_status[w[1:0] - 2'd1];
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
      if (w[5:4] == 2'b01 && taken) begin
        if (m_stack.size() == 4) begin
          m_err = 1'b1; taken = 1'b0;
        end else begin
          m_stack.push_back(m_pc + 1'b1);
        end
      end
`endif
      m_pc = taken ? t : m_pc + 1'b1;
    end
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    check("stack_err", o_stack_err, m_err);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [7:0] w;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Datapath word with one-cycle ack delay, then a second fetch at PC=1.
    mem[0] = 8'h05; mem[1] = 8'h11;
    do_reset();
    step(1);
    step(-1);

    // Conditional jump on status[1]: taken, then not taken.
    do_reset();
    mem[0] = 8'hC2; mem[1] = 8'h40; mem[8'h40] = 8'h22; mem[2] = 8'h33;
    set_status(3'b010);
    step(-1);
    step(-1);
    do_reset();
    set_status(3'b101);
    step(-1);
    step(-1);

    // PC wrap from 0xFF.
    do_reset();
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h05; mem[2] = 8'h00;
    step(-1);
    step(-1);
    step(-1);

    // Reset while a request is pending; the late ack must be ignored.
    do_reset();
    mem[0] = 8'h05;
    check("pre_abort_req", o_imem_req, 1);
    i_rst = 1'b1;
    @(negedge clk);
    check("abort_req", o_imem_req, 0);
    i_rst = 1'b0; i_imem_ack = 1'b1; i_imem_data = 8'hF0;
    @(negedge clk);
    i_imem_ack = 1'b0;
    step(-1);

    // Five nested CALLs then five RETs.
    do_reset();
    mem[8'h00] = 8'hD0; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hD0; mem[8'h11] = 8'h20;
    mem[8'h20] = 8'hD0; mem[8'h21] = 8'h30;
    mem[8'h30] = 8'hD0; mem[8'h31] = 8'h40;
    mem[8'h40] = 8'hD0; mem[8'h41] = 8'h50;
    mem[8'h42] = 8'hE0; mem[8'h32] = 8'hE0; mem[8'h22] = 8'hE0;
    mem[8'h12] = 8'hE0; mem[8'h02] = 8'hE0; mem[8'h03] = 8'h07;
    mem[8'h50] = 8'hE0; mem[8'h51] = 8'h09;
    for (int i = 0; i < 12; i++) step(-1);

    // HALT is terminal until reset.
    do_reset();
    mem[0] = 8'hF0;
    step(-1);
    do_reset();
    mem[0] = 8'h05;
    step(-1);

    // Randomized program.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      w = 8'($urandom);
      if (r < 65)      w[7:6] = 2'($urandom_range(0, 2));
      else if (r < 80) w = {4'b1100, w[3:0]};
      else if (r < 90) w = {4'b1101, w[3:0]};
      else if (r < 97) w = {4'b1110, w[3:0]};
      if (w[7:4] == 4'hF) w[6] = 1'b0;
      mem[i] = w;
    end
    for (int i = 0; i < 200; i++) step(-1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
